// File: rtl/instr_seq_pkg.sv
// Shared definitions for the fetch/issue sequencer and the opcode classifier.
package instr_seq_pkg;

  // Instruction format codes as presented on the fmt output
  typedef enum logic [1:0] {
    FmtIllegal = 2'd0,
    FmtI       = 2'd1,
    FmtII      = 2'd2,
    FmtJ       = 2'd3
  } fmt_e;

  // Sequencer state encodings
  localparam logic [2:0] SeqIdle     = 3'd0;
  localparam logic [2:0] SeqFetchOp  = 3'd1;
  localparam logic [2:0] SeqFetchSrc = 3'd2;
  localparam logic [2:0] SeqFetchDst = 3'd3;
  localparam logic [2:0] SeqIssue    = 3'd4;

  // Register numbers with special source-operand meaning
  localparam logic [3:0] RegPc = 4'd0;
  localparam logic [3:0] RegSr = 4'd2;
  localparam logic [3:0] RegCg = 4'd3;

  // Source addressing modes (As field)
  localparam logic [1:0] AmReg  = 2'b00;
  localparam logic [1:0] AmIdx  = 2'b01;
  localparam logic [1:0] AmInd  = 2'b10;
  localparam logic [1:0] AmIncr = 2'b11;

  // Source operand needs an extension word: x(Rn)/&abs, or #imm via @PC+.
  // R3 is the constant generator in every mode; R2 only with As=10/11, so
  // As=01 with R2 (&abs) still needs its word.
  function automatic logic src_needs_word(logic [1:0] as_mode, logic [3:0] rs);
    return ((as_mode == AmIdx) && (rs != RegCg)) || ((as_mode == AmIncr) && (rs == RegPc));
  endfunction

endpackage

// File: rtl/instr_seq_if.sv
// ROM-side fetch and execute-side issue signals of the instruction sequencer.
interface instr_seq_if;
  logic [15:0] mdb_in;
  logic        mdb_rdy;
  logic        fetch_req;
  logic        pc_inc;
  logic [15:0] instr;
  logic [15:0] src_ext;
  logic [15:0] dst_ext;
  logic [1:0]  fmt;
  logic [1:0]  n_ext;
  logic        illegal;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;

  // Sequencer side
  modport master (
    input  mdb_in, mdb_rdy, instr_ready, flush,
    output fetch_req, pc_inc, instr, src_ext, dst_ext, fmt, n_ext, illegal, instr_valid
  );

  // ROM / execute / environment side
  modport slave (
    output mdb_in, mdb_rdy, instr_ready, flush,
    input  fetch_req, pc_inc, instr, src_ext, dst_ext, fmt, n_ext, illegal, instr_valid
  );
endinterface

// File: rtl/instr_ext_cnt.sv
// Combinational opcode classifier: format, illegal flag and extension-word needs.
module instr_ext_cnt
  import instr_seq_pkg::*;
(
  input  logic [15:0] opcode,
  output logic [1:0]  fmt,
  output logic        need_src,
  output logic        need_dst,
  output logic        illegal
);

  // Byte/word select does not affect instruction length
  logic unused_bw;
  assign unused_bw = opcode[6];

  // Classify by the top nibble, then look at the addressing fields
  always_comb begin
    fmt      = FmtIllegal;
    need_src = 1'b0;
    need_dst = 1'b0;
    illegal  = 1'b0;
    if (opcode[15:12] == 4'h0) begin
      illegal = 1'b1;
    end else if (opcode[15:12] == 4'h1) begin
      fmt      = FmtII;
      need_src = src_needs_word(opcode[5:4], opcode[3:0]);
    end else if (opcode[15:13] == 3'b001) begin
      fmt = FmtJ;
    end else begin
      fmt      = FmtI;
      need_src = src_needs_word(opcode[5:4], opcode[11:8]);
      need_dst = opcode[7];
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Fetch/issue sequencer: fetches opcode plus extension words from ROM and
// presents the complete instruction bundle to execute with valid/ready.
module instr_seq
  import instr_seq_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  instr_seq_if.master bus
);

  logic [2:0]  state_q, state_d;
  logic [15:0] instr_q, src_ext_q, dst_ext_q;
  logic [1:0]  fmt_q, n_ext_q;
  logic        illegal_q, need_dst_q;

  logic [1:0]  dec_fmt;
  logic        dec_need_src, dec_need_dst, dec_illegal;
  logic        fetching;

  instr_ext_cnt u_ext_cnt (
    .opcode   (bus.mdb_in),
    .fmt      (dec_fmt),
    .need_src (dec_need_src),
    .need_dst (dec_need_dst),
    .illegal  (dec_illegal)
  );

  // fetch_req and instr_valid depend on the registered state only
  assign fetching        = (state_q == SeqFetchOp) || (state_q == SeqFetchSrc) ||
                           (state_q == SeqFetchDst);
  assign bus.fetch_req   = fetching;
  assign bus.instr_valid = (state_q == SeqIssue);
  assign bus.pc_inc      = fetching & bus.mdb_rdy & ~bus.flush;
  assign bus.instr       = instr_q;
  assign bus.src_ext     = src_ext_q;
  assign bus.dst_ext     = dst_ext_q;
  assign bus.fmt         = fmt_q;
  assign bus.n_ext       = n_ext_q;
  assign bus.illegal     = illegal_q;

  // Next state; flush wins over any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = SeqFetchOp;
    end else begin
      case (state_q)
        SeqIdle:     state_d = SeqFetchOp;
        SeqFetchOp:  if (bus.mdb_rdy) begin
                       state_d = dec_need_src ? SeqFetchSrc :
                                 dec_need_dst ? SeqFetchDst : SeqIssue;
                     end
        SeqFetchSrc: if (bus.mdb_rdy) state_d = need_dst_q ? SeqFetchDst : SeqIssue;
        SeqFetchDst: if (bus.mdb_rdy) state_d = SeqIssue;
        SeqIssue:    if (bus.instr_ready) state_d = SeqFetchOp;
        default:     state_d = SeqIdle;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SeqIdle;
    else        state_q <= state_d;
  end

  // Bundle registers, loaded only on an accepted (non-flushed) word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      src_ext_q  <= '0;
      dst_ext_q  <= '0;
      fmt_q      <= '0;
      n_ext_q    <= '0;
      illegal_q  <= 1'b0;
      need_dst_q <= 1'b0;
    end else if (bus.pc_inc) begin
      case (state_q)
        SeqFetchOp: begin
          instr_q    <= bus.mdb_in;
          src_ext_q  <= '0;
          dst_ext_q  <= '0;
          fmt_q      <= dec_fmt;
          n_ext_q    <= {1'b0, dec_need_src} + {1'b0, dec_need_dst};
          illegal_q  <= dec_illegal;
          need_dst_q <= dec_need_dst;
        end
        SeqFetchSrc: src_ext_q <= bus.mdb_in;
        SeqFetchDst: dst_ext_q <= bus.mdb_in;
        default: ;
      endcase
    end
  end

endmodule
